sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO with integrated write-side and read-side control.
- Generalises the fixed 8-bit, pointer-pair FIFO to configurable width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, and a read-data valid strobe.
- Sits between a producer and a consumer processor on the shared clock.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; must be a power of two, at least 4.
- ADDR_W, 4: log2(DEPTH); pointers are ADDR_W+1 bits, the extra MSB is the wrap bit.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_en  in  1  push request, sampled on clk.
- data_in  in  WIDTH  write data.
- read_en  in  1  pop request, sampled on clk.
- err_clr  in  1  synchronous clear of the sticky overflow/underflow flags.
- data_out  out  WIDTH  read data.
- data_valid  out  1  data_out holds a popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, release synchronous to clk): both pointers 0, count 0, data_out 0, data_valid 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0. Memory contents are not reset.
- Write accepted when write_en=1 and (!full, or read accepted in the same cycle). The word is stored at wr_ptr[ADDR_W-1:0], then wr_ptr increments.
- Read accepted when read_en=1 and !empty. The word at rd_ptr is registered into data_out, rd_ptr increments, and data_valid=1 on the following cycle. data_valid is 0 in any cycle after no accepted read, and data_out then holds its last value.
- Read latency: 1 cycle from read_en to data_out/data_valid.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- full/empty are derived from the pointers: equal pointers = empty; equal low bits with differing MSB = full. All flags are registered or pointer-derived, so they are valid in the cycle after the causing edge.
- Full with write_en and read_en together: both are accepted, count stays DEPTH, overflow is not set.
- Full with write only: write dropped, memory and pointers unchanged, overflow <= 1.
- Empty with read_en and write_en together: the write is accepted, the read is rejected, underflow <= 1, and data_valid stays 0.
- Empty with read only: underflow <= 1, pointers unchanged.
- Pointer wrap: the low bits roll DEPTH-1 -> 0 and the MSB toggles. There is no data corruption across the wrap.
- err_clr=1 clears overflow and underflow next cycle. If an error event occurs in the same cycle as err_clr, the set wins.
- Reset mid-operation: all state returns to reset values immediately; in-flight data is discarded.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - data_out continuously shows the head entry; data_valid = !empty.
  - read_en pops the head, and the next entry appears the following cycle.
  - A write into an empty FIFO is visible on data_out with data_valid=1 one cycle after the write edge.
  - Underflow rules are unchanged.
- Undefined: standard registered-read mode, as described above.

Test Plan:
- Reset, then write 0xA1, 0xB2, 0xC3 on consecutive cycles, then three reads -> data_out 0xA1, 0xB2, 0xC3, each with data_valid one cycle after its read_en; count goes 3 -> 0; empty=1.
- Write 16 words 0x00..0x0F -> full=1, almost_full=1 from count 14; a 17th write of 0xFF -> overflow=1 and count stays 16; read all 16 -> 0x00..0x0F, with 0xFF never output.
- From empty, read_en=1 -> underflow=1, data_valid=0; err_clr pulse -> underflow=0 next cycle.
- Fill to 16, then assert write_en and read_en together for 20 cycles -> count constant at 16, no overflow, output order preserved across pointer wrap.
- Reset asserted mid-stream at count=7 -> count=0, empty=1, flags cleared without waiting for a clk edge.
- With FIFO_FWFT_EN defined, write 0x5A to empty -> data_out=0x5A, data_valid=1 next cycle with no read_en; read_en -> data_valid=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky errors; 1-cycle registered read.
// Writes into a full FIFO are dropped unless a read frees a slot in the same cycle; FIFO_FWFT_EN selects first-word-fall-through.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read_en,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_L = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            rd_acc;
  logic            wr_acc;
  logic            full_w;
  logic            empty_w;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign rd_acc = read_en && !empty_w;
  assign wr_acc = write_en && (!full_w || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q && !err_clr;
    unf_d    = unf_q && !err_clr;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error event wins over a simultaneous clear.
    if (write_en && full_w && !rd_acc) begin
      ovf_d = 1'b1;
    end
    if (read_en && empty_w) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; zero while empty so stale memory never leaks out.
  always_comb begin
    data_out   = '0;
    data_valid = !empty_w;
    if (!empty_w) begin
      data_out = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvld_q, dvld_d;

  always_comb begin
    dout_d = dout_q;
    dvld_d = rd_acc;
    if (rd_acc) begin
      dout_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      dvld_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dvld_q <= dvld_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
`endif

  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    count_q == (wr_ptr_q - rd_ptr_q));
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (reset)
    !(full_w && empty_w));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: directed stimulus pushes expected read data, a negedge monitor checks it.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .err_clr(err_clr), .data_out(data_out),
    .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_dv  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_state(input string tag);
    int c;
    c = mq.size();
    check({tag, ".count"},        32'(count),        32'(c));
    check({tag, ".full"},         32'(full),         32'(c == 16));
    check({tag, ".empty"},        32'(empty),        32'(c == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(c >= 14));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 2));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    check({tag, ".data_valid"},   32'(data_valid),   32'(c != 0));
`else
    check({tag, ".data_valid"},   32'(data_valid),   32'(m_dv));
`endif
  endtask

  // Drive one cycle of stimulus, update the reference queue, check flags after the edge.
  task automatic cycle(input logic we, input logic [7:0] din, input logic re,
                       input logic clr, input string tag);
    bit rd_ok;
    bit wr_ok;
    write_en = we;
    data_in  = din;
    read_en  = re;
    err_clr  = clr;
    rd_ok = re && (mq.size() > 0);
    wr_ok = we && ((mq.size() < 16) || rd_ok);
    m_ovf = (m_ovf && !clr) || (we && (mq.size() == 16) && !rd_ok);
    m_unf = (m_unf && !clr) || (re && (mq.size() == 0));
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(din);
    m_dv = rd_ok;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  // Monitor: compares every word the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    bit take;
`ifdef FIFO_FWFT_EN
    take = !reset && read_en && data_valid;
`else
    take = !reset && data_valid;
`endif
    if (take) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got word 0x%0h, required no output", data_out);
      end else begin
        check("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vec3 [3];
    vec3[0] = 8'hA1;
    vec3[1] = 8'hB2;
    vec3[2] = 8'hC3;

    // Reset state, sampled before any clock edge.
    #2;
    check_state("reset");
    check("reset.data_out", 32'(data_out), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Three writes then three reads.
    foreach (vec3[i]) cycle(1'b1, vec3[i], 1'b0, 1'b0, "wr3");
    check("wr3.count_is_3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd3");
    idle("rd3_drain");
    check("rd3.empty_final", 32'(empty), 32'd1);

    // Fill to full, overflow attempt, drain.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ovf");
    check("ovf.count_16", 32'(count), 32'd16);
    check("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    idle("drain_tail");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");

    // Underflow, clear, set-wins-over-clear, write+read on empty.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "unf");
    check("unf.flag", 32'(underflow), 32'd1);
    check("unf.no_valid", 32'(data_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "unf_clr");
    check("unf_clr.flag", 32'(underflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "unf_vs_clr");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "unf_clr2");
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "empty_wr_rd");
    check("empty_wr_rd.count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "rd_77");
    idle("rd_77_tail");

    // Full with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, "fill2");
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, "rw_full");
    check("rw_full.no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    idle("drain2_tail");

    // Asynchronous reset in the middle of traffic at count 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, "pre_rst");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_rd");
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, "pre_rst_wr");
    check("pre_rst.count_7", 32'(count), 32'd7);
    #1;
    reset = 1'b1;
    #2;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dv  = 1'b0;
    check_state("mid_rst");
    check("mid_rst.data_out", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle("post_rst");

`ifdef FIFO_FWFT_EN
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, "fwft_wr");
    check("fwft_wr.data_out", 32'(data_out), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "fwft_rd");
    check("fwft_rd.empty", 32'(empty), 32'd1);
`endif

    idle("final");
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
